// File: rtl/pcu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcu_pkg
// Description : Shared constants for the trap / clock-control unit: CSR
//               addresses, FSM state encoding and trap cause codes.
// Revision    : 1.0 - initial release
// ============================================================================
package pcu_pkg;

  // CSR address map
  localparam logic [11:0] c_csr_mtvec  = 12'h305;
  localparam logic [11:0] c_csr_mepc   = 12'h341;
  localparam logic [11:0] c_csr_mcause = 12'h342;
  localparam logic [11:0] c_csr_mtval  = 12'h343;
  localparam logic [11:0] c_csr_mipd   = 12'h100;

  // FSM state encoding
  localparam int          c_st_w       = 2;
  localparam logic [1:0]  c_st_idle    = 2'd0;
  localparam logic [1:0]  c_st_halt    = 2'd1;
  localparam logic [1:0]  c_st_handler = 2'd2;

  // Cause codes reported in mcause (source i reports cause i+1)
  localparam logic [3:0]  c_cause_prog_brk   = 4'd1;
  localparam logic [3:0]  c_cause_user_brk   = 4'd2;
  localparam logic [3:0]  c_cause_div_zero   = 4'd3;
  localparam logic [3:0]  c_cause_mem_err    = 4'd4;
  localparam logic [3:0]  c_cause_decode_err = 4'd5;

endpackage
`default_nettype wire

// File: rtl/pcu_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : pcu_clk_gen
// Description : Divides the fast clock into the CPU clock, produces the
//               tick strobe (last fast cycle before a cpu_clk rising edge)
//               and gates the CPU clock with a run enable that is only
//               allowed to change on tick.
// Ports       : clk        - fast system clock
//               rstn       - asynchronous active-low reset
//               i_run_req  - desired run state, loaded on tick
//               o_tick     - last fast cycle of a CPU cycle
//               o_cpu_clk  - divided, gated CPU clock (registered)
//               o_cpu_stop - high while the CPU clock is held
// Revision    : 1.0 - initial release
// ============================================================================
module pcu_clk_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_run_req,
  output logic o_tick,
  output logic o_cpu_clk,
  output logic o_cpu_stop
);

  localparam int               CNT_W      = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(CLK_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_run_en;
  logic             w_run_nxt;
  logic             r_cpu_clk;

  assign o_tick    = (r_cnt == c_cnt_last);
  assign w_cnt_nxt = o_tick ? '0 : r_cnt + CNT_W'(1);
  // Run enable changes only where the divided clock is about to rise from
  // its low phase, so a high phase is never cut short.
  assign w_run_nxt = o_tick ? i_run_req : r_run_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_run_en  <= 1'b0;
      r_cpu_clk <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_run_en  <= w_run_nxt;
      // Registered AND of the next divider phase and next enable keeps the
      // CPU clock output free of combinational glitches.
      r_cpu_clk <= (w_cnt_nxt < c_cnt_half) & w_run_nxt;
    end
  end

  assign o_cpu_clk  = r_cpu_clk;
  assign o_cpu_stop = ~r_run_en;

endmodule
`default_nettype wire

// File: rtl/pcu_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pcu_trap_ctrl
// Description : Trap and clock-control unit. Prioritises NUM_SRC trap
//               requests, either vectors to a handler or halts the CPU
//               clock, owns the machine CSRs and drives pipeline
//               flush/redirect.
// Ports       : clk, rstn            - fast clock, async active-low reset
//               i_src_req            - trap request lines (lowest index wins)
//               i_trap_pc/i_trap_val - PC and auxiliary value of the trap
//               i_mret, i_resume     - handler return, debug run pulse
//               i_csr_*              - CSR read/write port
//               o_csr_rdata          - combinational CSR read data
//               o_cpu_clk/o_cpu_stop - gated CPU clock and hold status
//               o_flush/o_redirect_* - one CPU cycle pipeline redirect
//               o_in_handler         - vectored handler active
// Revision    : 1.0 - initial release
// ============================================================================
module pcu_trap_ctrl #(
  parameter int                 NUM_SRC    = 8,
  parameter int                 XLEN       = 32,
  parameter int                 CLK_DIV    = 5,
  parameter logic [XLEN-1:0]    TRAP_BASE  = 32'h0000_F000,
  parameter int                 VEC_STRIDE = 4,
  parameter logic [NUM_SRC-1:0] HALT_MASK  = 8'b0000_0011
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] i_src_req,
  input  logic [XLEN-1:0]    i_trap_pc,
  input  logic [XLEN-1:0]    i_trap_val,
  input  logic               i_mret,
  input  logic               i_resume,
  input  logic [11:0]        i_csr_raddr,
  output logic [XLEN-1:0]    o_csr_rdata,
  input  logic [11:0]        i_csr_waddr,
  input  logic [XLEN-1:0]    i_csr_wdata,
  input  logic               i_csr_wen,
  output logic               o_cpu_clk,
  output logic               o_cpu_stop,
  output logic               o_flush,
  output logic               o_redirect_valid,
  output logic [XLEN-1:0]    o_redirect_pc,
  output logic               o_in_handler
);

  import pcu_pkg::*;

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic              w_tick;
  logic              w_run_req;

  logic [c_st_w-1:0] r_state;
  logic [c_st_w-1:0] w_state_nxt;
  logic              r_ret_handler;   // halt was entered from the handler
  logic              w_ret_handler_nxt;

  logic              w_req_any;
  logic [IDX_W-1:0]  w_req_idx;
  logic              w_req_halt;

  logic              w_capture;       // hardware CSR capture this tick
  logic              w_enter;         // vector into handler
  logic              w_exit;          // return from handler

  logic              r_redir;
  logic [XLEN-1:0]   r_redirect_pc;
  logic [XLEN-1:0]   w_vec_pc;
  logic              w_sw_wr;

  logic [XLEN-1:0]   r_mtvec;
  logic [XLEN-1:0]   r_mepc;
  logic [XLEN-1:0]   r_mcause;
  logic [XLEN-1:0]   r_mtval;
  logic [XLEN-1:0]   r_mipd;

  // --------------------------------------------------------------------------
  // Clock divider / gating
  // --------------------------------------------------------------------------
  pcu_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .rstn       (rstn),
    .i_run_req  (w_run_req),
    .o_tick     (w_tick),
    .o_cpu_clk  (o_cpu_clk),
    .o_cpu_stop (o_cpu_stop)
  );

  // The CPU clock runs in every state except HALT.
  assign w_run_req = (w_state_nxt != c_st_halt);

  // --------------------------------------------------------------------------
  // Priority encoder: scanning downwards leaves the lowest asserted index.
  // --------------------------------------------------------------------------
  always_comb begin
    w_req_any = 1'b0;
    w_req_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_src_req[i]) begin
        w_req_any = 1'b1;
        w_req_idx = IDX_W'(i);
      end
    end
  end

  assign w_req_halt = w_req_any & HALT_MASK[w_req_idx];
  assign w_vec_pc   = r_mtvec + XLEN'(w_req_idx) * XLEN'(VEC_STRIDE);
  assign w_sw_wr    = w_tick & i_csr_wen;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= c_st_halt;
      r_ret_handler <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ret_handler <= w_ret_handler_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic (all transitions on tick only)
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_ret_handler_nxt = r_ret_handler;
    w_capture         = 1'b0;
    w_enter           = 1'b0;
    w_exit            = 1'b0;
    if (w_tick) begin
      case (r_state)
        c_st_idle: begin
          if (w_req_any) begin
            w_capture = 1'b1;
            if (w_req_halt) begin
              w_state_nxt       = c_st_halt;
              w_ret_handler_nxt = 1'b0;
            end else begin
              w_enter     = 1'b1;
              w_state_nxt = c_st_handler;
            end
          end
        end
        c_st_halt: begin
          if (i_resume) begin
            w_state_nxt = r_ret_handler ? c_st_handler : c_st_idle;
          end
        end
        c_st_handler: begin
          // mepc is left untouched here so the handler can still return.
          if (w_req_halt) begin
            w_state_nxt       = c_st_halt;
            w_ret_handler_nxt = 1'b1;
          end else if (i_mret || (r_mipd == XLEN'(1))) begin
            w_exit      = 1'b1;
            w_state_nxt = c_st_idle;
          end
        end
        default: begin
          w_state_nxt = c_st_halt;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_in_handler = (r_state == c_st_handler) ||
                   ((r_state == c_st_halt) && r_ret_handler);
  end

  // Redirect pulse is loaded on tick, so it spans exactly one CPU cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_redir       <= 1'b0;
      r_redirect_pc <= '0;
    end else if (w_tick) begin
      r_redir <= w_enter | w_exit;
      if (w_enter) begin
        r_redirect_pc <= w_vec_pc;
      end else if (w_exit) begin
        r_redirect_pc <= r_mepc;
      end
    end
  end

  assign o_flush          = r_redir;
  assign o_redirect_valid = r_redir;
  assign o_redirect_pc    = r_redirect_pc;

  // --------------------------------------------------------------------------
  // CSR file: hardware capture takes precedence over a same-tick write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mtvec  <= {TRAP_BASE[XLEN-1:2], 2'b00};
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
      r_mipd   <= '0;
    end else begin
      if (w_sw_wr && (i_csr_waddr == c_csr_mtvec)) begin
        r_mtvec <= {i_csr_wdata[XLEN-1:2], 2'b00};
      end

      if (w_capture) begin
        r_mepc <= i_trap_pc;
      end else if (w_sw_wr && (i_csr_waddr == c_csr_mepc)) begin
        r_mepc <= i_csr_wdata;
      end

      if (w_capture) begin
        r_mcause <= XLEN'(w_req_idx) + XLEN'(1);
      end else if (w_sw_wr && (i_csr_waddr == c_csr_mcause)) begin
        r_mcause <= i_csr_wdata;
      end

      if (w_capture) begin
        r_mtval <= i_trap_val;
      end else if (w_sw_wr && (i_csr_waddr == c_csr_mtval)) begin
        r_mtval <= i_csr_wdata;
      end

      if (w_capture || w_exit) begin
        r_mipd <= '0;
      end else if (w_sw_wr && (i_csr_waddr == c_csr_mipd)) begin
        r_mipd <= i_csr_wdata;
      end
    end
  end

  always_comb begin
    case (i_csr_raddr)
      c_csr_mtvec:  o_csr_rdata = r_mtvec;
      c_csr_mepc:   o_csr_rdata = r_mepc;
      c_csr_mcause: o_csr_rdata = r_mcause;
      c_csr_mtval:  o_csr_rdata = r_mtval;
      c_csr_mipd:   o_csr_rdata = r_mipd;
      default:      o_csr_rdata = '0;
    endcase
  end

endmodule
`default_nettype wire
